// File: rtl/banco_registradores_pkg.sv
// Package: pkg_processador
// Shared constants for the single-cycle datapath register file.
//   LARGURA_ENDERECO_REG : width of a register address
//   N_REGS               : number of architectural registers
//   REG_ZERO             : address of the hardwired-zero register
//   LARGURA_CONTADOR     : width of the committed-write counter
package pkg_processador;

   localparam int unsigned LARGURA_ENDERECO_REG = 3;
   localparam int unsigned N_REGS               = 8;
   localparam logic [LARGURA_ENDERECO_REG-1:0] REG_ZERO = 3'd0;
   localparam int unsigned LARGURA_CONTADOR     = 16;

endpackage

// File: rtl/banco_registradores.sv
// Module: banco_registradores
// Register file of the single-cycle datapath: 8 registers, R0 hardwired to zero.
// Two combinational read ports (optional write-to-read bypass), one debug read port
// (never bypassed), one synchronous write port, and a counter of committed writes.
// Ports:
//   Clock             rising-edge clock
//   Reset             asynchronous, active-low; clears registers and counter
//   EscritaHabilitada write enable
//   EnderecoEscrita   write address (from the destination mux)
//   DadoEscrita       write data
//   EnderecoLeitura1  read address, port 1
//   EnderecoLeitura2  read address, port 2
//   Dado1 / Dado2     read data, ports 1 and 2
//   EnderecoDebug     debug read address
//   DadoDebug         debug read data, stored value only
//   ContagemEscritas  committed-write count, wraps at 16 bits
module banco_registradores #(
   parameter int unsigned         LARGURA     = 8,
   parameter int unsigned         N_REGS      = pkg_processador::N_REGS,
   parameter bit                  BYPASS      = 1'b1,
   parameter logic [LARGURA-1:0]  VALOR_RESET = '0
) (
   input  logic                                              Clock,
   input  logic                                              Reset,
   input  logic                                              EscritaHabilitada,
   input  logic [pkg_processador::LARGURA_ENDERECO_REG-1:0]  EnderecoEscrita,
   input  logic [LARGURA-1:0]                                DadoEscrita,
   input  logic [pkg_processador::LARGURA_ENDERECO_REG-1:0]  EnderecoLeitura1,
   input  logic [pkg_processador::LARGURA_ENDERECO_REG-1:0]  EnderecoLeitura2,
   output logic [LARGURA-1:0]                                Dado1,
   output logic [LARGURA-1:0]                                Dado2,
   input  logic [pkg_processador::LARGURA_ENDERECO_REG-1:0]  EnderecoDebug,
   output logic [LARGURA-1:0]                                DadoDebug,
   output logic [pkg_processador::LARGURA_CONTADOR-1:0]      ContagemEscritas
);

   import pkg_processador::*;

   typedef logic [LARGURA_ENDERECO_REG-1:0] endereco_t;
   typedef logic [LARGURA-1:0]              dado_t;

   // Flops rather than RAM: needs reset and three independent read ports.
   dado_t                         regs_q [N_REGS];
   logic [LARGURA_CONTADOR-1:0]   contagem_q;
   logic                          escrita_valida;

   // Writes to R0 are discarded and not counted.
   assign escrita_valida = EscritaHabilitada && (EnderecoEscrita != REG_ZERO);

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < N_REGS; i++) begin
            regs_q[i] <= (i == 0) ? '0 : VALOR_RESET;
         end
         contagem_q <= '0;
      end else if (escrita_valida) begin
         regs_q[EnderecoEscrita] <= DadoEscrita;
         contagem_q              <= contagem_q + 1'b1;
      end
   end

   // Read mux shared by both operand ports: R0 forces zero, then bypass, then storage.
   function automatic dado_t ler(input endereco_t end_leitura,
                                 input dado_t     armazenado,
                                 input logic      valida,
                                 input endereco_t end_escrita,
                                 input dado_t     dado_escrita);
      if (end_leitura == REG_ZERO) begin
         return '0;
      end else if (BYPASS && valida && (end_leitura == end_escrita)) begin
         return dado_escrita;
      end else begin
         return armazenado;
      end
   endfunction

   assign Dado1 = ler(EnderecoLeitura1, regs_q[EnderecoLeitura1], escrita_valida,
                      EnderecoEscrita, DadoEscrita);
   assign Dado2 = ler(EnderecoLeitura2, regs_q[EnderecoLeitura2], escrita_valida,
                      EnderecoEscrita, DadoEscrita);

   assign DadoDebug        = (EnderecoDebug == REG_ZERO) ? '0 : regs_q[EnderecoDebug];
   assign ContagemEscritas = contagem_q;

   // Undefined address lines during a write are illegal.
   a_endereco_definido : assert property (
      @(posedge Clock) disable iff (!Reset)
      EscritaHabilitada |-> !$isunknown({EnderecoEscrita, EnderecoLeitura1, EnderecoLeitura2})
   ) else $error("banco_registradores: X/Z on address lines during write");

endmodule

// File: tb/tb_banco_registradores.sv
// Directed self-checking bench for banco_registradores (BYPASS=1, VALOR_RESET=8'h5A).
module tb_banco_registradores;

   localparam logic [7:0] VR = 8'h5A;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        EscritaHabilitada;
   logic [2:0]  EnderecoEscrita;
   logic [7:0]  DadoEscrita;
   logic [2:0]  EnderecoLeitura1;
   logic [2:0]  EnderecoLeitura2;
   logic [7:0]  Dado1;
   logic [7:0]  Dado2;
   logic [2:0]  EnderecoDebug;
   logic [7:0]  DadoDebug;
   logic [15:0] ContagemEscritas;

   int checks   = 0;
   int failures = 0;

   banco_registradores #(
      .LARGURA     (8),
      .BYPASS      (1'b1),
      .VALOR_RESET (VR)
   ) dut (
      .Clock             (Clock),
      .Reset             (Reset),
      .EscritaHabilitada (EscritaHabilitada),
      .EnderecoEscrita   (EnderecoEscrita),
      .DadoEscrita       (DadoEscrita),
      .EnderecoLeitura1  (EnderecoLeitura1),
      .EnderecoLeitura2  (EnderecoLeitura2),
      .Dado1             (Dado1),
      .Dado2             (Dado2),
      .EnderecoDebug     (EnderecoDebug),
      .DadoDebug         (DadoDebug),
      .ContagemEscritas  (ContagemEscritas)
   );

   always #5 Clock = ~Clock;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Edge, then settle 1 time unit so sampling is away from the edge.
   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // Behavioural stand-in for the 3:1 x 3-bit destination mux.
   function automatic logic [2:0] mux3_3(input logic [1:0] controle);
      case (controle)
         2'b00:   return 3'd7;
         2'b01:   return 3'd2;
         default: return 3'd0;
      endcase
   endfunction

   initial begin
      Reset             = 1'b0;
      EscritaHabilitada = 1'b0;
      EnderecoEscrita   = 3'd0;
      DadoEscrita       = 8'h00;
      EnderecoLeitura1  = 3'd0;
      EnderecoLeitura2  = 3'd0;
      EnderecoDebug     = 3'd0;
      #2 Reset = 1'b1;

      // Dirty R1 and R7 so the mid-cycle reset has something to clear.
      EscritaHabilitada = 1'b1; EnderecoEscrita = 3'd1; DadoEscrita = 8'h11;
      tick();
      EnderecoEscrita = 3'd7; DadoEscrita = 8'h77;
      tick();
      EscritaHabilitada = 1'b0;
      EnderecoLeitura1 = 3'd1; EnderecoLeitura2 = 3'd7; EnderecoDebug = 3'd0;
      #1;
      check_eq("pre_reset_r1", Dado1, 8'h11);
      check_eq("pre_reset_cnt", ContagemEscritas, 16'd2);

      // 1. Mid-cycle reset pulse, no clock edge.
      #1 Reset = 1'b0;
      #1;
      check_eq("rst_dado1_r1", Dado1, VR);
      check_eq("rst_dado2_r7", Dado2, VR);
      check_eq("rst_debug_r0", DadoDebug, 8'h00);
      check_eq("rst_cnt", ContagemEscritas, 16'd0);
      EnderecoDebug = 3'd4;
      #1;
      check_eq("rst_debug_r4", DadoDebug, VR);
      Reset = 1'b1;

      // 2. Write A5 to R3, read back next cycle.
      tick();
      EscritaHabilitada = 1'b1; EnderecoEscrita = 3'd3; DadoEscrita = 8'hA5;
      EnderecoLeitura1 = 3'd4;
      tick();
      EscritaHabilitada = 1'b0; EnderecoLeitura1 = 3'd3;
      #1;
      check_eq("wr_r3_dado1", Dado1, 8'hA5);
      check_eq("wr_r3_cnt", ContagemEscritas, 16'd1);

      // 3. Write to R0 is discarded and not counted; no bypass at address 0.
      EscritaHabilitada = 1'b1; EnderecoEscrita = 3'd0; DadoEscrita = 8'hFF;
      EnderecoLeitura1 = 3'd0; EnderecoLeitura2 = 3'd0; EnderecoDebug = 3'd0;
      #1;
      check_eq("r0_bypass_dado1", Dado1, 8'h00);
      tick();
      EscritaHabilitada = 1'b0;
      #1;
      check_eq("r0_dado1", Dado1, 8'h00);
      check_eq("r0_dado2", Dado2, 8'h00);
      check_eq("r0_debug", DadoDebug, 8'h00);
      check_eq("r0_cnt", ContagemEscritas, 16'd1);

      // 4. Bypass on both ports; debug shows old value until the edge.
      EscritaHabilitada = 1'b1; EnderecoEscrita = 3'd5; DadoEscrita = 8'h3C;
      EnderecoLeitura1 = 3'd5; EnderecoLeitura2 = 3'd5; EnderecoDebug = 3'd5;
      #1;
      check_eq("byp_dado1", Dado1, 8'h3C);
      check_eq("byp_dado2", Dado2, 8'h3C);
      check_eq("byp_debug_old", DadoDebug, VR);
      tick();
      check_eq("byp_debug_new", DadoDebug, 8'h3C);
      check_eq("byp_cnt", ContagemEscritas, 16'd2);
      // Writing a different address must not disturb the R5 read.
      EnderecoEscrita = 3'd6; DadoEscrita = 8'h66; EnderecoLeitura2 = 3'd6;
      #1;
      check_eq("nobyp_dado1", Dado1, 8'h3C);
      check_eq("byp_other_dado2", Dado2, 8'h66);
      tick();
      EscritaHabilitada = 1'b0;
      #1;
      check_eq("stored_r6", Dado2, 8'h66);
      check_eq("byp_disabled_cnt", ContagemEscritas, 16'd3);

      // 5. Write address from the destination mux: 7, 2, then 0 (dropped).
      EscritaHabilitada = 1'b1;
      for (int c = 0; c < 3; c++) begin
         EnderecoEscrita = mux3_3(2'(c));
         DadoEscrita     = 8'hC0 | 8'(c);
         tick();
      end
      EscritaHabilitada = 1'b0;
      EnderecoLeitura1 = 3'd7; EnderecoLeitura2 = 3'd2; EnderecoDebug = 3'd0;
      #1;
      check_eq("mux_r7", Dado1, 8'hC0);
      check_eq("mux_r2", Dado2, 8'hC1);
      check_eq("mux_r0", DadoDebug, 8'h00);
      check_eq("mux_cnt", ContagemEscritas, 16'd5);

      // 6a. Reset held low across a write edge to R4: reset wins.
      EscritaHabilitada = 1'b1; EnderecoEscrita = 3'd4; DadoEscrita = 8'h44;
      EnderecoDebug = 3'd4;
      #1 Reset = 1'b0;
      tick();
      Reset = 1'b1; EscritaHabilitada = 1'b0;
      #1;
      check_eq("coll_r4", DadoDebug, VR);
      check_eq("coll_cnt", ContagemEscritas, 16'd0);

      // 6b. Drive the counter to 16'hFFFF with real writes, then one more wraps it.
      EscritaHabilitada = 1'b1; EnderecoEscrita = 3'd1; DadoEscrita = 8'h12;
      repeat (65535) @(posedge Clock);
      #1;
      EscritaHabilitada = 1'b0;
      #1;
      check_eq("cnt_ffff", ContagemEscritas, 16'hFFFF);
      EscritaHabilitada = 1'b1; DadoEscrita = 8'h99; EnderecoDebug = 3'd1;
      tick();
      EscritaHabilitada = 1'b0;
      #1;
      check_eq("cnt_wrap", ContagemEscritas, 16'h0000);
      check_eq("wrap_r1", DadoDebug, 8'h99);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
